// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) helpers, state layout and FSM encoding.
package aes_pkg;

  // Byte 0 is the most significant byte, so state[4*c + r] is row r of column c.
  typedef logic [0:15][7:0] state_t;

  typedef enum logic [0:0] {StIdle, StRun} aes_st_e;

  localparam logic [7:0] RconInit = 8'h01;

  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b)+7, i.e. {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes128_round_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the current one.
module aes128_round_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rc,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  // RotWord then SubWord, with rc folded into the leading byte.
  assign t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_cfb_e.sv
// AES-128 CFB-128 decryption: plain = cipher XOR AES_enc(key, chain), one round per clock.
module aes128_cfb_e
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         iv_load,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic [127:0] cipher_in,
  output logic [127:0] plain_out,
  output logic         out_valid
);

  aes_st_e      st_q, st_d;
  state_t       state_q, state_d;
  logic [127:0] rkey_q, rkey_d, cin_q, cin_d, chain_q, chain_d, plain_q, plain_d;
  logic [7:0]   rc_q, rc_d;
  logic [3:0]   round_q, round_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] next_key;
  state_t       sb, sr, mc, round_out;
  logic         last_round;

  aes128_round_key_step u_key_step (
    .key      (rkey_q),
    .rc       (rc_q),
    .next_key (next_key)
  );

  // SubBytes, ShiftRows, MixColumns, AddRoundKey on the current state.
  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_q[i]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) mc[4*c +: 4] = mix_column(sr[4*c +: 4]);
    last_round = (round_q == 4'd10);
    round_out  = (last_round ? sr : mc) ^ next_key;
  end

  always_comb begin
    st_d        = st_q;
    state_d     = state_q;
    rkey_d      = rkey_q;
    rc_d        = rc_q;
    round_d     = round_q;
    cin_d       = cin_q;
    chain_d     = chain_q;
    plain_d     = plain_q;
    out_valid_d = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          cin_d   = cipher_in;
          state_d = (iv_load ? iv : chain_q) ^ key;
          rkey_d  = key;
          rc_d    = RconInit;
          round_d = 4'd1;
          st_d    = StRun;
        end
      end
      StRun: begin
        state_d = round_out;
        rkey_d  = next_key;
        rc_d    = xtime(rc_q);
        round_d = round_q + 4'd1;
        if (last_round) begin
          plain_d     = cin_q ^ round_out;
          out_valid_d = 1'b1;
          chain_d     = cin_q;
          round_d     = 4'd0;
          st_d        = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      state_q     <= '0;
      rkey_q      <= '0;
      rc_q        <= '0;
      round_q     <= '0;
      cin_q       <= '0;
      chain_q     <= '0;
      plain_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      rc_q        <= rc_d;
      round_q     <= round_d;
      cin_q       <= cin_d;
      chain_q     <= chain_d;
      plain_q     <= plain_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (st_q == StIdle);
  assign plain_out = plain_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes128_cfb_e.sv
// Directed bench for aes128_cfb_e using FIPS-197 and SP800-38A CFB128 vectors.
module tb_aes128_cfb_e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         iv_load = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic [127:0] cipher_in = '0;
  logic         in_ready;
  logic [127:0] plain_out;
  logic         out_valid;

  int nvec = 0;
  int nerr = 0;

  localparam logic [127:0] SpKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SpIv  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] C2 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
  localparam logic [127:0] C3 = 128'h26751f67a3cbb140b1808cf187a4f4df;
  localparam logic [127:0] C4 = 128'hc04b05357c5d1c0eeac4c66f9ff7f2e6;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;

  always #5 clk = ~clk;

  aes128_cfb_e dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .iv_load   (iv_load),
    .key       (key),
    .iv        (iv),
    .cipher_in (cipher_in),
    .plain_out (plain_out),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one block, wait (bounded) for out_valid, check latency and result.
  // With intrude set, a different block is held on the inputs while the core is busy.
  task automatic run_block(input string tag, input logic ivl, input logic [127:0] k,
                           input logic [127:0] v, input logic [127:0] c,
                           input logic [127:0] exp, input bit intrude);
    int n;
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    iv_load   = ivl;
    key       = k;
    iv        = v;
    cipher_in = c;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = intrude;
    if (intrude) begin
      key       = ~k;
      cipher_in = ~c;
      iv_load   = 1'b1;
      iv        = ~v;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (intrude && lat == 5) check({tag, " busy in_ready"}, {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    check({tag, " latency"}, lat, 128'd10);
    check(tag, plain_out, exp);
  endtask

  initial begin
    int pulses;

    repeat (2) @(negedge clk);
    check("reset plain_out", plain_out, 128'd0);
    check("reset out_valid", {127'd0, out_valid}, 128'd0);
    check("reset in_ready", {127'd0, in_ready}, 128'd1);
    rst_n = 1'b1;

    run_block("fips197", 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 128'd0,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);

    run_block("cfb blk1", 1'b1, SpKey, SpIv, C1, P1, 1'b0);
    run_block("cfb blk2", 1'b0, SpKey, 128'd0, C2, P2, 1'b0);
    run_block("cfb blk3", 1'b0, SpKey, 128'd0, C3, P3, 1'b0);
    run_block("cfb blk4", 1'b0, SpKey, 128'd0, C4, P4, 1'b0);

    run_block("ext iv blk2", 1'b1, SpKey, C1, C2, P2, 1'b0);

    run_block("keystream", 1'b1, SpKey, SpIv, 128'd0,
              128'h50fe67cc996d32b6da0937e99bafec60, 1'b0);

    run_block("busy", 1'b1, SpKey, SpIv, C1, P1, 1'b1);
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("busy extra pulses", pulses, 128'd0);
    check("busy result held", plain_out, P1);

    // Abort a block with reset partway through.
    @(negedge clk);
    in_valid  = 1'b1;
    iv_load   = 1'b1;
    key       = SpKey;
    iv        = SpIv;
    cipher_in = C1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort plain_out", plain_out, 128'd0);
    check("abort out_valid", {127'd0, out_valid}, 128'd0);
    check("abort in_ready", {127'd0, in_ready}, 128'd1);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("abort no pulse", pulses, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Chain is zero after reset: AES(0-key, 0-block) is the well-known 66e94bd4... value.
    run_block("post reset chain", 1'b0, 128'd0, 128'd0, 128'd0,
              128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/aes128_cfb_e.md
Name: aes128_cfb_e

Overview:
- AES-128 CFB-128 decryption datapath: plain_out = cipher_in XOR AES128_Encrypt(key, chain), where chain is the feedback block (the IV or the previous ciphertext).
- Iterative core that computes one AES round per clock, with on-the-fly key expansion.
- Sits between a block source (file/stream reader) and a plaintext sink; processes one 128-bit block per transaction.

Parameters:
- none (AES-128 and CFB-128 are fixed)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  block request; accepted when in_valid && in_ready
- in_ready  out  1  high when idle and able to accept a block
- iv_load  in  1  sampled on accept; 1 = use the iv port as feedback, 0 = use the stored previous ciphertext
- key  in  128  cipher key, sampled on accept
- iv  in  128  initialisation vector, sampled on accept when iv_load=1
- cipher_in  in  128  ciphertext block, sampled on accept
- plain_out  out  128  decrypted block, registered
- out_valid  out  1  one-cycle pulse when plain_out is updated

Behaviour:
- Byte order: byte 0 = bits [127:120]; the AES state is column-major as in FIPS-197.
- Reset (async assert, sync deassert by the surrounding system):
  - plain_out=0, out_valid=0, in_ready=1
  - round counter=0, chain register=0, state and key registers=0
- FSM states: IDLE, RUN.
  - IDLE: in_ready=1.
  - On accept:
    - latch cipher_in, key and the feedback block (iv if iv_load, else the chain register)
    - state <= feedback XOR key (initial AddRoundKey)
    - round key register <= key, rc <= 8'h01, round <= 1
    - go to RUN.
- RUN: in_ready=0; one round per cycle.
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey(next round key).
  - Round 10 omits MixColumns.
  - Next round key is generated combinationally in the same cycle from the current round key: RotWord, SubWord, XOR rc, then the word cascade.
  - rc advances by xtime (GF(2^8) multiply by 2, reduction 0x1b): 01,02,…,80,1b,36.
- Completion, on the round-10 cycle:
  - plain_out <= latched cipher_in XOR the round-10 result
  - out_valid=1 for exactly one cycle
  - chain register <= latched cipher_in
  - return to IDLE
- Latency: accept at edge N → out_valid high after edge N+10 (10 cycles); in_ready high again in that same cycle. Throughput is one block per 11 cycles (back-to-back accept is allowed in the cycle out_valid is high).
- in_valid while in_ready=0 is ignored; input ports may change freely during RUN.
- iv_load=0 on the first block after reset uses chain=0.
- Reset asserted mid-RUN aborts the block: no out_valid, all registers return to reset values.
- key may differ per block; there is no cached key schedule.

Decomposition:
- Package aes_pkg:
  - 256-entry S-box constant plus a sbox() function
  - xtime() function and mix_column() function
  - state typedef (16 x 8-bit array)
  - Rcon start value 8'h01
- One sub-module: aes128_round_key_step.
  - Inputs: round key, rc. Output: next round key.
  - Uses 4 S-box lookups.
- The datapath round logic (16 S-box lookups, ShiftRows, MixColumns) stays inline in aes128_cfb_e.

Test Plan:
- FIPS-197 core check: key=000102030405060708090a0b0c0d0e0f, iv_load=1, iv=00112233445566778899aabbccddeeff, cipher_in=0 → plain_out=69c4e0d86a7b0430d8cdb78070b4c55a, exactly 10 cycles after accept.
- SP800-38A CFB128 chained decrypt:
  - Setup: key=2b7e151628aed2a6abf7158809cf4f3c, iv=000102030405060708090a0b0c0d0e0f.
  - Block 1, iv_load=1: cipher_in=3b3fd92eb72dad20333449f8e83cfb4a → plain_out=6bc1bee22e409f96e93d7e117393172a.
  - Block 2, iv_load=0: c8a64537a0b3a93fcde3cdad9f1ce58b → ae2d8a571e03ac9c9eb76fac45af8e51.
  - Block 3, iv_load=0: 26751f67a3cbb140b1808cf187a4f4df → 30c81c46a35ce411e5fbc1191a0a52ef.
  - Block 4, iv_load=0: c04b05357c5d1c0eeac4c66f9ff7f2e6 → f69f2445df4f9b17ad2b417be66c3710.
- External-IV equivalence: repeat block 2 with iv_load=1 and iv=3b3fd92eb72dad20333449f8e83cfb4a → same ae2d8a57… result.
- Busy handling: assert in_valid with a different block during RUN → ignored; only one out_valid pulse; the first result is unchanged.
- Reset mid-block: drop rst_n at cycle 5 of a block → outputs zero immediately, no out_valid; then block 1 with iv_load=0 uses chain=0, giving plain_out = cipher_in XOR AES(key, 0).
- Keystream check: SP800-38A key and IV with cipher_in=0 → plain_out=50fe67cc996d32b6da0937e99bafec60.
